pc_sequencer: RTL and testbench

Multi-cycle control sequencer for the OTTER MCU. It owns the fetch/execute/writeback state machine and the branch-condition decision, and it generates the 3-bit `pcSource` select for the next-PC multiplexer, the PC write strobe and the memory/register/CSR enables. Trap entry (mtvec) and `mret` return (mepc) are included. It sits between instruction memory, the branch comparator, the CSR file and the PC register/mux.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Sequencer control bundle: decoded instruction fields and branch flags in, PC/memory/regfile/CSR strobes out.
// Purely combinational signal grouping; no flow control.
interface pc_sequencer_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       br_eq;
    logic       br_lt;
    logic       br_ltu;
    logic       intr;
    logic       mie;

    logic       pc_rst;
    logic       PCWrite;
    logic [2:0] pcSource;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       memWE2;
    logic       regWrite;
    logic [1:0] rf_wr_sel;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;

    modport master (
        input  opcode, func3, br_eq, br_lt, br_ltu, intr, mie,
        output pc_rst, PCWrite, pcSource, memRDEN1, memRDEN2, memWE2,
               regWrite, rf_wr_sel, csr_WE, int_taken, mret_exec
    );

    modport slave (
        output opcode, func3, br_eq, br_lt, br_ltu, intr, mie,
        input  pc_rst, PCWrite, pcSource, memRDEN1, memRDEN2, memWE2,
               regWrite, rf_wr_sel, csr_WE, int_taken, mret_exec
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle OTTER control FSM: 2 cycles per instruction, 3 for loads, +1 on trap entry.
// Outputs are combinational from state and current instruction; no backpressure, the core always advances.
module pc_sequencer (
    input  logic          CLK,
    input  logic          RST_N,
    pc_sequencer_if.master bus
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_INTR  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;
    logic   br_taken;
    logic   is_mret;
    logic   trap_req;

    assign is_mret  = (bus.opcode == OP_SYSTEM) && (bus.func3 == 3'b000);
    assign trap_req = bus.intr && bus.mie;

    always_comb begin
        br_taken = 1'b0;
        case (bus.func3)
            3'b000:  br_taken =  bus.br_eq;
            3'b001:  br_taken = !bus.br_eq;
            3'b100:  br_taken =  bus.br_lt;
            3'b101:  br_taken = !bus.br_lt;
            3'b110:  br_taken =  bus.br_ltu;
            3'b111:  br_taken = !bus.br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_INIT;
        else        state <= next_state;
    end

    // mret returns straight to FETCH so the restored PC is fetched before any new trap
    always_comb begin
        next_state = S_INIT;
        case (state)
            S_INIT:  next_state = S_FETCH;
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                if (bus.opcode == OP_LOAD)      next_state = S_WB;
                else if (is_mret)               next_state = S_FETCH;
                else if (trap_req)              next_state = S_INTR;
                else                            next_state = S_FETCH;
            end
            S_WB:    next_state = trap_req ? S_INTR : S_FETCH;
            S_INTR:  next_state = S_FETCH;
            default: next_state = S_INIT;
        endcase
    end

    always_comb begin
        bus.pc_rst    = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.pcSource  = 3'd0;
        bus.memRDEN1  = 1'b0;
        bus.memRDEN2  = 1'b0;
        bus.memWE2    = 1'b0;
        bus.regWrite  = 1'b0;
        bus.rf_wr_sel = 2'd0;
        bus.csr_WE    = 1'b0;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        case (state)
            S_INIT:  bus.pc_rst   = 1'b1;
            S_FETCH: bus.memRDEN1 = 1'b1;
            S_EXEC: begin
                bus.PCWrite = 1'b1;
                case (bus.opcode)
                    OP_LUI, OP_AUIPC, OP_IMM, OP_OP: begin
                        bus.regWrite  = 1'b1;
                        bus.rf_wr_sel = 2'd3;
                    end
                    OP_JAL: begin
                        bus.regWrite = 1'b1;
                        bus.pcSource = 3'd3;
                    end
                    OP_JALR: begin
                        bus.regWrite = 1'b1;
                        bus.pcSource = 3'd1;
                    end
                    OP_BRANCH: bus.pcSource = br_taken ? 3'd2 : 3'd0;
                    OP_STORE:  bus.memWE2   = 1'b1;
                    OP_LOAD: begin
                        bus.memRDEN2 = 1'b1;
                        bus.PCWrite  = 1'b0;
                    end
                    OP_SYSTEM: begin
                        if (is_mret) begin
                            bus.pcSource  = 3'd5;
                            bus.mret_exec = 1'b1;
                        end else if (bus.func3 == 3'b001 || bus.func3 == 3'b010 ||
                                     bus.func3 == 3'b011) begin
                            bus.csr_WE    = 1'b1;
                            bus.regWrite  = 1'b1;
                            bus.rf_wr_sel = 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                bus.regWrite  = 1'b1;
                bus.rf_wr_sel = 2'd2;
                bus.PCWrite   = 1'b1;
            end
            S_INTR: begin
                bus.PCWrite   = 1'b1;
                bus.pcSource  = 3'd4;
                bus.int_taken = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer: per-instruction expected output
// vectors are queued by the driver and compared each cycle by an independent monitor.
module tb_pc_sequencer;

    typedef struct packed {
        logic       pc_rst;
        logic       pcwrite;
        logic [2:0] pcsrc;
        logic       rden1;
        logic       rden2;
        logic       we2;
        logic       regwr;
        logic [1:0] wsel;
        logic       csrwe;
        logic       intt;
        logic       mret;
    } ov_t;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, OPIMM = 7'b0010011,
                           OPR = 7'b0110011, JAL = 7'b1101111, JALR = 7'b1100111,
                           BRANCH = 7'b1100011, STORE = 7'b0100011, LOAD = 7'b0000011,
                           SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    logic rst_n;
    pc_sequencer_if bus();

    pc_sequencer dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    always #5 clk = ~clk;

    ov_t   exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    // ---------------- reference model ----------------
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq, lt, ltu);
        case (f3)
            3'd0: return eq;       // BEQ
            3'd1: return !eq;      // BNE
            3'd4: return lt;       // BLT
            3'd5: return !lt;      // BGE
            3'd6: return ltu;      // BLTU
            3'd7: return !ltu;     // BGEU
            default: return 1'b0;
        endcase
    endfunction

    function automatic ov_t exec_vec(input logic [6:0] op, input logic [2:0] f3,
                                     input logic eq, lt, ltu);
        ov_t o = '0;
        o.pcwrite = 1'b1;
        if (op == LUI || op == AUIPC || op == OPIMM || op == OPR) begin
            o.regwr = 1'b1; o.wsel = 2'd3;
        end else if (op == JAL) begin
            o.regwr = 1'b1; o.pcsrc = 3'd3;
        end else if (op == JALR) begin
            o.regwr = 1'b1; o.pcsrc = 3'd1;
        end else if (op == BRANCH) begin
            o.pcsrc = branch_taken(f3, eq, lt, ltu) ? 3'd2 : 3'd0;
        end else if (op == STORE) begin
            o.we2 = 1'b1;
        end else if (op == LOAD) begin
            o.rden2 = 1'b1; o.pcwrite = 1'b0;
        end else if (op == SYSTEM && f3 == 3'd0) begin
            o.pcsrc = 3'd5; o.mret = 1'b1;
        end else if (op == SYSTEM && f3 >= 3'd1 && f3 <= 3'd3) begin
            o.csrwe = 1'b1; o.regwr = 1'b1; o.wsel = 2'd1;
        end
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input ov_t e, input string tag, input logic irq, input logic ie,
                       input logic rst);
        bus.intr = irq;
        bus.mie  = ie;
        rst_n    = !rst;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic eq, lt, ltu, input logic irq, input logic ie,
                             input logic rst_last);
        ov_t fetch_v = '0;
        ov_t wb_v    = '0;
        ov_t intr_v  = '0;
        ov_t init_v  = '0;
        logic is_load = (op == LOAD);
        logic trap    = irq && ie && !(op == SYSTEM && f3 == 3'd0);
        fetch_v.rden1 = 1'b1;
        wb_v.regwr = 1'b1; wb_v.wsel = 2'd2; wb_v.pcwrite = 1'b1;
        intr_v.pcwrite = 1'b1; intr_v.pcsrc = 3'd4; intr_v.intt = 1'b1;
        init_v.pc_rst = 1'b1;

        bus.opcode = op; bus.func3 = f3;
        bus.br_eq = eq; bus.br_lt = lt; bus.br_ltu = ltu;
        cyc(fetch_v, "fetch", rb(), rb(), 1'b0);
        if (is_load) begin
            // an interrupt during a load's EXEC must not divert it from WB
            cyc(exec_vec(op, f3, eq, lt, ltu), "exec_load", rb(), rb(), 1'b0);
            cyc(wb_v, "wb", irq, ie, rst_last && !trap);
        end else begin
            cyc(exec_vec(op, f3, eq, lt, ltu), "exec", irq, ie, rst_last && !trap);
        end
        if (trap) cyc(intr_v, "intr", rb(), rb(), rst_last);
        if (rst_last) cyc(init_v, "init_after_rst", rb(), rb(), 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ov_t   got;
        ov_t   e;
        string t;
        if (exp_q.size() > 0) begin
            got = {bus.pc_rst, bus.PCWrite, bus.pcSource, bus.memRDEN1, bus.memRDEN2,
                   bus.memWE2, bus.regWrite, bus.rf_wr_sel, bus.csr_WE, bus.int_taken,
                   bus.mret_exec};
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b (op=%b f3=%b)", t, got, e,
                         bus.opcode, bus.func3);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        ov_t init_v;
        logic [6:0] ops [10];
        ops = '{LUI, AUIPC, OPIMM, OPR, JAL, JALR, BRANCH, STORE, LOAD, SYSTEM};
        init_v = '0;
        init_v.pc_rst = 1'b1;

        rst_n = 1'b0;
        bus.opcode = '0; bus.func3 = '0; bus.br_eq = 1'b0; bus.br_lt = 1'b0;
        bus.br_ltu = 1'b0; bus.intr = 1'b0; bus.mie = 1'b0;
        @(posedge clk);
        #1;
        cyc(init_v, "reset", 1'b0, 1'b0, 1'b1);
        cyc(init_v, "reset", 1'b0, 1'b0, 1'b1);
        cyc(init_v, "reset_release", 1'b0, 1'b0, 1'b0);

        run_instr(OPIMM, 3'd0, 0, 0, 0, 0, 0, 0);               // ADDI
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++)
                run_instr(BRANCH, 3'(f), c[0], c[1], c[2], 0, 0, 0);
        run_instr(LOAD, 3'd2, 0, 0, 0, 0, 0, 0);                // LW
        run_instr(LOAD, 3'd2, 0, 0, 0, 1, 1, 0);                // LW then trap after WB
        run_instr(OPR, 3'd0, 0, 0, 0, 1, 1, 0);                 // ADD with trap
        run_instr(OPR, 3'd0, 0, 0, 0, 1, 0, 0);                 // ADD, MIE clear
        run_instr(SYSTEM, 3'd0, 0, 0, 0, 1, 1, 0);              // MRET ignores intr
        run_instr(SYSTEM, 3'd1, 0, 0, 0, 0, 0, 0);              // CSRRW
        run_instr(SYSTEM, 3'd4, 0, 0, 0, 0, 0, 0);              // unsupported SYSTEM
        run_instr(7'b1111111, 3'd0, 0, 0, 0, 0, 0, 0);          // unknown opcode
        run_instr(BRANCH, 3'd0, 1, 0, 0, 1, 1, 0);              // taken branch + trap
        run_instr(LOAD, 3'd2, 0, 0, 0, 0, 0, 1);                // reset during WB
        run_instr(OPR, 3'd0, 0, 0, 0, 1, 1, 1);                 // reset during INTR

        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            run_instr(op, 3'($urandom), rb(), rb(), rb(), rb(), rb(),
                      $urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
